wb_arbiter: RTL and testbench



---
 rtl/wb_pkg.sv | 13 +
 rtl/wb_fifo.sv | 56 +++++
 rtl/wb_arbiter.sv | 102 ++++++++++
 tb/tb_wb_arbiter.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared types and constants for the writeback arbiter slice.
package wb_pkg;

    localparam int LQ_DEPTH_DEFAULT = 4;
    localparam int THREADS          = 8;

    typedef struct packed {
        logic [2:0]  trd;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests; count/flags come straight from registers.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = LQ_DEPTH_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  wb_req_t                  din,
    input  logic                     pop,
    output wb_req_t                  head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    wb_req_t         mem [DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Merges execute results, queued load returns and thread-spawn inits onto the
// register-file write port and thread-init port; all wr_*/*_wb outputs are flops.
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int LQ_DEPTH = LQ_DEPTH_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        exe_valid,
    input  logic [2:0]                  exe_trd,
    input  logic [4:0]                  exe_rd,
    input  logic [31:0]                 exe_data,
    input  logic                        mem_valid,
    input  logic [2:0]                  mem_trd,
    input  logic [4:0]                  mem_rd,
    input  logic [31:0]                 mem_data,
    output logic                        mem_ready,
    input  logic                        spawn_valid,
    input  logic [2:0]                  spawn_trd,
    input  logic [31:0]                 spawn_data,
    output logic                        spawn_ready,
    output logic                        wr_en,
    output logic [2:0]                  wr_trd,
    output logic [4:0]                  reg_wr,
    output logic [31:0]                 wr_data,
    output logic                        init_wb,
    output logic [2:0]                  new_trd_wb,
    output logic [31:0]                 init_data_wb,
    output logic [$clog2(LQ_DEPTH):0]   lq_cnt
);

    wb_req_t  lq_din;
    wb_req_t  lq_head;
    logic     lq_push;
    logic     lq_pop;
    logic     lq_full;
    logic     lq_empty;

    wb_req_t  sel_req;
    logic     sel_valid;
    logic     spawn_acc;

    assign lq_din    = '{trd: mem_trd, rd: mem_rd, data: mem_data};
    assign mem_ready = !lq_full;
    assign lq_push   = mem_valid && mem_ready;

    wb_fifo #(.DEPTH(LQ_DEPTH)) u_lq (
        .clk   (clk),
        .rst   (rst),
        .push  (lq_push),
        .din   (lq_din),
        .pop   (lq_pop),
        .head  (lq_head),
        .count (lq_cnt),
        .full  (lq_full),
        .empty (lq_empty)
    );

    // Execute results cannot stall, so they always beat the load queue.
    always_comb begin
        sel_req   = lq_head;
        sel_valid = 1'b0;
        lq_pop    = 1'b0;
        if (exe_valid) begin
            sel_req   = '{trd: exe_trd, rd: exe_rd, data: exe_data};
            sel_valid = 1'b1;
        end else if (!lq_empty) begin
            sel_valid = 1'b1;
            lq_pop    = 1'b1;
        end
    end

    assign spawn_ready = !(sel_valid && (sel_req.trd == spawn_trd));
    assign spawn_acc   = spawn_valid && spawn_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_en        <= 1'b0;
            wr_trd       <= '0;
            reg_wr       <= '0;
            wr_data      <= '0;
            init_wb      <= 1'b0;
            new_trd_wb   <= '0;
            init_data_wb <= '0;
        end else begin
            wr_en   <= sel_valid && (sel_req.rd != '0);
            init_wb <= spawn_acc && (spawn_trd != '0);
            if (sel_valid) begin
                wr_trd  <= sel_req.trd;
                reg_wr  <= sel_req.rd;
                wr_data <= sel_req.data;
            end
            // Thread 0 is acknowledged but never re-initialised.
            if (spawn_acc && (spawn_trd != '0)) begin
                new_trd_wb   <= spawn_trd;
                init_data_wb <= spawn_data;
            end
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        exe_valid = 1'b0;
    logic [2:0]  exe_trd = '0;
    logic [4:0]  exe_rd = '0;
    logic [31:0] exe_data = '0;
    logic        mem_valid = 1'b0;
    logic [2:0]  mem_trd = '0;
    logic [4:0]  mem_rd = '0;
    logic [31:0] mem_data = '0;
    logic        mem_ready;
    logic        spawn_valid = 1'b0;
    logic [2:0]  spawn_trd = '0;
    logic [31:0] spawn_data = '0;
    logic        spawn_ready;
    logic        wr_en;
    logic [2:0]  wr_trd;
    logic [4:0]  reg_wr;
    logic [31:0] wr_data;
    logic        init_wb;
    logic [2:0]  new_trd_wb;
    logic [31:0] init_data_wb;
    logic [2:0]  lq_cnt;

    int vectors = 0;
    int miscompares = 0;

    wb_arbiter #(.LQ_DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .exe_valid    (exe_valid),
        .exe_trd      (exe_trd),
        .exe_rd       (exe_rd),
        .exe_data     (exe_data),
        .mem_valid    (mem_valid),
        .mem_trd      (mem_trd),
        .mem_rd       (mem_rd),
        .mem_data     (mem_data),
        .mem_ready    (mem_ready),
        .spawn_valid  (spawn_valid),
        .spawn_trd    (spawn_trd),
        .spawn_data   (spawn_data),
        .spawn_ready  (spawn_ready),
        .wr_en        (wr_en),
        .wr_trd       (wr_trd),
        .reg_wr       (reg_wr),
        .wr_data      (wr_data),
        .init_wb      (init_wb),
        .new_trd_wb   (new_trd_wb),
        .init_data_wb (init_data_wb),
        .lq_cnt       (lq_cnt)
    );

    always #5 clk = ~clk;

    // Advance one edge and land 1 time unit after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        #1;
        vectors++;
        if (wr_en !== 1'b0 || init_wb !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_strobes: wr_en=%b init_wb=%b required 0 0", wr_en, init_wb);
        end
        vectors++;
        if (lq_cnt !== 3'd0 || mem_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_queue: lq_cnt=%0d mem_ready=%b required 0 1", lq_cnt, mem_ready);
        end
        vectors++;
        if (wr_trd !== 3'd0 || reg_wr !== 5'd0 || wr_data !== 32'd0 ||
            new_trd_wb !== 3'd0 || init_data_wb !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_data: wr_trd=%0d reg_wr=%0d wr_data=%h new_trd=%0d init_data=%h required all 0",
                     wr_trd, reg_wr, wr_data, new_trd_wb, init_data_wb);
        end
    endtask

    task automatic test_exe();
        exe_valid = 1'b1; exe_trd = 3'd3; exe_rd = 5'd5; exe_data = 32'hDEADBEEF;
        step();
        exe_valid = 1'b0;
        vectors++;
        if (wr_en !== 1'b1 || wr_trd !== 3'd3 || reg_wr !== 5'd5 || wr_data !== 32'hDEADBEEF) begin
            miscompares++;
            $display("FAIL exe_write: wr_en=%b trd=%0d rd=%0d data=%h required 1 3 5 deadbeef",
                     wr_en, wr_trd, reg_wr, wr_data);
        end
        step();
        vectors++;
        if (wr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL exe_pulse: wr_en=%b required 0", wr_en);
        end
    endtask

    task automatic test_queue_fill();
        logic [2:0] exp_cnt [5];
        exp_cnt = '{3'd3, 3'd3, 3'd2, 3'd1, 3'd0};
        exe_valid = 1'b1; exe_trd = 3'd7; exe_rd = 5'd1; exe_data = 32'h0;
        for (int i = 0; i < 4; i++) begin
            mem_valid = 1'b1; mem_trd = 3'd2; mem_rd = 5'(10 + i); mem_data = 32'h100 + i;
            #1;
            vectors++;
            if (mem_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL fill_ready[%0d]: mem_ready=%b required 1", i, mem_ready);
            end
            step();
        end
        mem_rd = 5'd14; mem_data = 32'h104;
        #1;
        vectors++;
        if (lq_cnt !== 3'd4 || mem_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL fill_full: lq_cnt=%0d mem_ready=%b required 4 0", lq_cnt, mem_ready);
        end
        step();
        vectors++;
        if (lq_cnt !== 3'd4 || wr_trd !== 3'd7) begin
            miscompares++;
            $display("FAIL fill_hold: lq_cnt=%0d wr_trd=%0d required 4 7", lq_cnt, wr_trd);
        end
        exe_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (i == 1) mem_valid = 1'b0;
            vectors++;
            if (wr_en !== 1'b1 || wr_trd !== 3'd2 || reg_wr !== 5'(10 + i) ||
                wr_data !== 32'h100 + i || lq_cnt !== exp_cnt[i]) begin
                miscompares++;
                $display("FAIL drain[%0d]: wr_en=%b trd=%0d rd=%0d data=%h cnt=%0d required 1 2 %0d %h %0d",
                         i, wr_en, wr_trd, reg_wr, wr_data, lq_cnt, 10 + i, 32'h100 + i, exp_cnt[i]);
            end
        end
        step();
        vectors++;
        if (wr_en !== 1'b0 || lq_cnt !== 3'd0) begin
            miscompares++;
            $display("FAIL drain_idle: wr_en=%b lq_cnt=%0d required 0 0", wr_en, lq_cnt);
        end
    endtask

    task automatic test_r0_load();
        mem_valid = 1'b1; mem_trd = 3'd2; mem_rd = 5'd0; mem_data = 32'h1234;
        step();
        mem_valid = 1'b0;
        vectors++;
        if (wr_en !== 1'b0 || lq_cnt !== 3'd1) begin
            miscompares++;
            $display("FAIL r0_push: wr_en=%b lq_cnt=%0d required 0 1", wr_en, lq_cnt);
        end
        step();
        vectors++;
        if (wr_en !== 1'b0 || lq_cnt !== 3'd0) begin
            miscompares++;
            $display("FAIL r0_pop: wr_en=%b lq_cnt=%0d required 0 0", wr_en, lq_cnt);
        end
        step();
        vectors++;
        if (wr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL r0_after: wr_en=%b required 0", wr_en);
        end
    endtask

    task automatic test_spawn_conflict();
        exe_valid = 1'b1; exe_trd = 3'd4; exe_rd = 5'd3; exe_data = 32'h77;
        spawn_valid = 1'b1; spawn_trd = 3'd4; spawn_data = 32'h55;
        #1;
        vectors++;
        if (spawn_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL spawn_block: spawn_ready=%b required 0", spawn_ready);
        end
        step();
        exe_valid = 1'b0;
        #1;
        vectors++;
        if (init_wb !== 1'b0 || spawn_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL spawn_retry: init_wb=%b spawn_ready=%b required 0 1", init_wb, spawn_ready);
        end
        step();
        spawn_valid = 1'b0;
        vectors++;
        if (init_wb !== 1'b1 || new_trd_wb !== 3'd4 || init_data_wb !== 32'h55) begin
            miscompares++;
            $display("FAIL spawn_init: init_wb=%b trd=%0d data=%h required 1 4 55",
                     init_wb, new_trd_wb, init_data_wb);
        end
        step();
        vectors++;
        if (init_wb !== 1'b0) begin
            miscompares++;
            $display("FAIL spawn_pulse: init_wb=%b required 0", init_wb);
        end
    endtask

    task automatic test_spawn_parallel();
        exe_valid = 1'b1; exe_trd = 3'd1; exe_rd = 5'd2; exe_data = 32'h11;
        spawn_valid = 1'b1; spawn_trd = 3'd6; spawn_data = 32'h80;
        #1;
        vectors++;
        if (spawn_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL par_ready: spawn_ready=%b required 1", spawn_ready);
        end
        step();
        exe_valid = 1'b0;
        spawn_trd = 3'd0; spawn_data = 32'h99;
        vectors++;
        if (wr_en !== 1'b1 || wr_trd !== 3'd1 || init_wb !== 1'b1 ||
            new_trd_wb !== 3'd6 || init_data_wb !== 32'h80) begin
            miscompares++;
            $display("FAIL par_both: wr_en=%b wr_trd=%0d init_wb=%b new_trd=%0d init_data=%h required 1 1 1 6 80",
                     wr_en, wr_trd, init_wb, new_trd_wb, init_data_wb);
        end
        vectors++;
        if (spawn_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL t0_ready: spawn_ready=%b required 1", spawn_ready);
        end
        step();
        spawn_valid = 1'b0;
        vectors++;
        if (init_wb !== 1'b0 || wr_en !== 1'b0) begin
            miscompares++;
            $display("FAIL t0_drop: init_wb=%b wr_en=%b required 0 0", init_wb, wr_en);
        end
    endtask

    task automatic test_reset_flush();
        exe_valid = 1'b1; exe_trd = 3'd5; exe_rd = 5'd9; exe_data = 32'hA5;
        for (int i = 0; i < 3; i++) begin
            mem_valid = 1'b1; mem_trd = 3'd3; mem_rd = 5'(20 + i); mem_data = 32'h200 + i;
            step();
        end
        mem_valid = 1'b0;
        vectors++;
        if (lq_cnt !== 3'd3 || wr_en !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_pre: lq_cnt=%0d wr_en=%b required 3 1", lq_cnt, wr_en);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        exe_valid = 1'b0;
        vectors++;
        if (lq_cnt !== 3'd0 || wr_en !== 1'b0 || mem_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flush_rst: lq_cnt=%0d wr_en=%b mem_ready=%b required 0 0 1",
                     lq_cnt, wr_en, mem_ready);
        end
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if (wr_en !== 1'b0 || lq_cnt !== 3'd0) begin
                miscompares++;
                $display("FAIL flush_stale[%0d]: wr_en=%b lq_cnt=%0d required 0 0", i, wr_en, lq_cnt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_exe();
        test_queue_fill();
        test_r0_load();
        test_spawn_conflict();
        test_spawn_parallel();
        test_reset_flush();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
